// File: rtl/ternary_serial_alu.sv
// rtl/ternary_serial_alu.sv - bit-serial balanced-width ternary ALU, one trit per cycle
//
// Purpose: latches two TRITS-trit operands and an op, then processes one trit
// per clock (LSB first) for TRITS cycles and presents the result until taken.
// Trit encoding: 00=0, 01=1, 10=2, 11=invalid. Trit i lives in bits [2i+1:2i].
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operands/op presented        in_ready   idle, can accept
//   op         000 MIN, 001 MAX, 010 CONSENSUS, 011 ANY, 100 ADD, others reserved
//   a, b       operands (2*TRITS bits)
//   result     registered result            carry_out  final ADD carry trit
//   error      invalid trit or reserved op  out_valid  result/carry_out/error valid
//   out_ready  consumer accepts the result

module ternary_serial_alu #(
  parameter int TRITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [2*TRITS-1:0] a,
  input  logic [2*TRITS-1:0] b,
  output logic [2*TRITS-1:0] result,
  output logic [1:0]         carry_out,
  output logic               error,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int              IW       = (TRITS > 1) ? $clog2(TRITS) : 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(TRITS - 1);

  localparam logic [2:0] OP_MIN  = 3'b000;
  localparam logic [2:0] OP_MAX  = 3'b001;
  localparam logic [2:0] OP_CONS = 3'b010;
  localparam logic [2:0] OP_ANY  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2*TRITS-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [1:0]         carry_q, carry_d;
  logic               error_q, error_d;

  // Current-trit datapath
  logic [1:0] ta, tb, trit_res, trit_carry;
  logic [2:0] pair_sum, add_sum;
  logic       trit_bad, op_reserved;

  always_comb begin
    ta          = a_q[{idx_q, 1'b0} +: 2];
    tb          = b_q[{idx_q, 1'b0} +: 2];
    trit_bad    = (ta == 2'b11) || (tb == 2'b11);
    op_reserved = (op_q > OP_ADD);
    pair_sum    = {1'b0, ta} + {1'b0, tb};
    add_sum     = pair_sum + {1'b0, carry_q};
    trit_res    = 2'b00;
    trit_carry  = 2'b00;
    case (op_q)
      OP_MIN:  trit_res = (ta < tb) ? ta : tb;
      OP_MAX:  trit_res = (ta > tb) ? ta : tb;
      OP_CONS: begin
        if (ta == 2'd2 && tb == 2'd2)      trit_res = 2'd2;
        else if (ta == 2'd0 && tb == 2'd0) trit_res = 2'd0;
        else                               trit_res = 2'd1;
      end
      // clamp(a+b-1, 0, 2)
      OP_ANY: begin
        if (pair_sum == 3'd0)      trit_res = 2'd0;
        else if (pair_sum >= 3'd3) trit_res = 2'd2;
        else                       trit_res = 2'(pair_sum - 3'd1);
      end
      // carry in is at most 1, so the sum never exceeds 5
      OP_ADD: begin
        if (add_sum >= 3'd3) begin
          trit_res   = 2'(add_sum - 3'd3);
          trit_carry = 2'd1;
        end else begin
          trit_res   = add_sum[1:0];
        end
      end
      default: trit_res = 2'b00;
    endcase
    // Invalid trits and reserved ops contribute a zero trit and kill the carry
    if (trit_bad || op_reserved) begin
      trit_res   = 2'b00;
      trit_carry = 2'b00;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      carry_q  <= 2'b00;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)           state_d = S_BUSY;
      S_BUSY:  if (idx_q == LAST_IDX)  state_d = S_DONE;
      S_DONE:  if (out_ready)          state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    error_d  = error_q;
    if (state_q == S_IDLE && in_valid) begin
      a_d      = a;
      b_d      = b;
      op_d     = op;
      idx_d    = '0;
      carry_d  = 2'b00;
      result_d = '0;
      error_d  = 1'b0;
    end else if (state_q == S_BUSY) begin
      result_d[{idx_q, 1'b0} +: 2] = trit_res;
      carry_d = trit_carry;
      error_d = error_q | trit_bad | op_reserved;
      idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
    carry_out = carry_q;
    error     = error_q;
  end

endmodule

// File: tb/tb_ternary_serial_alu.sv
// tb/tb_ternary_serial_alu.sv - randomized self-checking bench for ternary_serial_alu

module tb_ternary_serial_alu;

  localparam int TRITS = 4;
  localparam int W     = 2 * TRITS;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, error, out_valid;
  logic [W-1:0] result;
  logic [1:0]   carry_out;

  ternary_serial_alu #(.TRITS(TRITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .result(result), .carry_out(carry_out),
    .error(error), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] r;
    logic [1:0]   c;
    logic         e;
  } exp_t;

  // Reference: integer trit arithmetic straight from the operation definitions
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] o);
    exp_t x;
    int carry, ta, tb, t, s;
    x = '0;
    carry = 0;
    for (int i = 0; i < TRITS; i++) begin
      ta = int'(av[2*i +: 2]);
      tb = int'(bv[2*i +: 2]);
      t  = 0;
      if (o > 3'd4) begin
        x.e = 1'b1;
      end else if (ta == 3 || tb == 3) begin
        x.e = 1'b1;
        carry = 0;
      end else begin
        case (o)
          3'd0: t = (ta < tb) ? ta : tb;
          3'd1: t = (ta > tb) ? ta : tb;
          3'd2: t = (ta == 2 && tb == 2) ? 2 : ((ta == 0 && tb == 0) ? 0 : 1);
          3'd3: begin
            t = ta + tb - 1;
            if (t < 0) t = 0;
            if (t > 2) t = 2;
          end
          default: begin
            s = ta + tb + carry;
            t = s % 3;
            carry = s / 3;
          end
        endcase
      end
      x.r[2*i +: 2] = t[1:0];
    end
    x.c = carry[1:0];
    return x;
  endfunction

  // Protocol model: 0 idle, 1 busy, 2 done
  int   m_phase = 0;
  int   m_cnt = 0;
  exp_t m_exp = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_exp   = model(a, b, op);
             m_cnt   = 0;
             m_phase = 1;
           end
        1: begin
             m_cnt++;
             if (m_cnt == TRITS) m_phase = 2;
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("result", 32'(result), 32'(m_exp.r));
        chk("carry_out", 32'(carry_out), 32'(m_exp.c));
        chk("error", 32'(error), 32'(m_exp.e));
      end
    end
  end

  function automatic logic [W-1:0] rnd_operand(input bit allow_bad);
    logic [W-1:0] v;
    logic [1:0]   t;
    v = '0;
    for (int i = 0; i < TRITS; i++) begin
      t = 2'($urandom_range(0, 2));
      if (allow_bad && $urandom_range(0, 7) == 0) t = 2'b11;
      v[2*i +: 2] = t;
    end
    return v;
  endfunction

  // Called 2 time units after a rising edge with the DUT idle
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] o);
    in_valid = 1'b1;
    a = av;
    b = bv;
    op = o;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 3'($urandom);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [2:0] o,
                        input bit lit, input logic [W-1:0] er, input logic [1:0] ec, input logic ee,
                        input int hold, input bit noise);
    int n;
    bit seen;
    accept(av, bv, o);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
      end else begin
        #1;
        if (noise) begin
          out_ready = 1'($urandom_range(0, 1));
          in_valid = 1'($urandom_range(0, 1));
          a = W'($urandom);
          b = W'($urandom);
          op = 3'($urandom);
        end
      end
    end
    chk("latency", 32'(n), 32'(TRITS));
    if (!seen) begin
      #1;
      reset = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      return;
    end
    if (lit) begin
      chk("lit_result", 32'(result), 32'(er));
      chk("lit_carry", 32'(carry_out), 32'(ec));
      chk("lit_error", 32'(error), 32'(ee));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (lit) begin
        chk("hold_result", 32'(result), 32'(er));
        chk("hold_in_ready", 32'(in_ready), 32'(0));
      end
    end
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_carry", 32'(carry_out), 32'(0));
    chk("rst_error", 32'(error), 32'(0));
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    run_op(8'hAA, 8'h01, 3'b100, 1'b1, 8'h00, 2'b01, 1'b0, 0, 1'b0);
    run_op(8'h18, 8'h91, 3'b000, 1'b1, 8'h10, 2'b00, 1'b0, 1, 1'b0);
    run_op(8'h18, 8'h91, 3'b001, 1'b1, 8'h99, 2'b00, 1'b0, 0, 1'b0);
    run_op(8'h5A, 8'h19, 3'b011, 1'b1, 8'h1A, 2'b00, 1'b0, 0, 1'b0);
    run_op(8'hA1, 8'h81, 3'b010, 1'b1, 8'h91, 2'b00, 1'b0, 0, 1'b0);
    run_op(8'h03, 8'h00, 3'b100, 1'b1, 8'h00, 2'b00, 1'b1, 0, 1'b0);
    run_op(8'hAA, 8'h55, 3'b110, 1'b1, 8'h00, 2'b00, 1'b1, 0, 1'b0);
    run_op(8'h59, 8'h26, 3'b100, 1'b1, 8'h94, 2'b00, 1'b0, 0, 1'b0);
    // Long hold in DONE with bus noise while busy
    run_op(8'h5A, 8'h19, 3'b011, 1'b1, 8'h1A, 2'b00, 1'b0, 5, 1'b1);

    // Abort in the second busy cycle
    accept(8'hAA, 8'h01, 3'b100);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    chk("abort_out_valid", 32'(out_valid), 32'(0));
    chk("abort_result", 32'(result), 32'(0));
    #1;
    reset = 1'b0;
    run_op(8'h59, 8'h26, 3'b100, 1'b1, 8'h94, 2'b00, 1'b0, 0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      logic [2:0] o;
      o = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      run_op(rnd_operand(k % 3 == 0), rnd_operand(k % 5 == 0), o,
             1'b0, '0, 2'b00, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
